// File: rtl/rf_pkg.sv
// Shared definitions for the rf_sb register file / scoreboard:
// default geometry, the per-cycle protocol-error cause record and
// the popcount helper that produces busycount.
package rf_pkg;

    localparam int RF_DEFAULT_WIDTH = 16;
    localparam int RF_DEFAULT_DEPTH = 8;
    // Largest supported register count; popcount works on a vector this wide.
    localparam int RF_MAX_DEPTH     = 256;

    // One bit per protocol-violation cause detected in a single cycle.
    typedef struct packed {
        logic wr_oob;    // writeback strobe with out-of-range select
        logic wr_unres;  // writeback to a register that is not busy
        logic rsv_oob;   // reserve strobe with out-of-range select
        logic rsv_dup;   // reserve of an already-busy register with no same-cycle writeback
    } rf_err_t;

    // Number of set bits in a (zero-padded) busy vector. Result fits 0..256.
    function automatic logic [8:0] popcount(input logic [RF_MAX_DEPTH-1:0] v);
        logic [8:0] c;
        c = '0;
        for (int i = 0; i < RF_MAX_DEPTH; i++) begin
            c = c + {8'd0, v[i]};
        end
        return c;
    endfunction

endpackage

// File: rtl/rf_entry.sv
// One register-file entry: a WIDTH-bit data word plus its pending-write
// (busy) flag. Reserve wins over a same-cycle writeback clear, so a
// back-to-back reissue keeps the register busy while the data lands.
module rf_entry
    import rf_pkg::*;
#(
    parameter int WIDTH = RF_DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             we,
    input  logic             re,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] data,
    output logic             busy,
    output logic             busy_next
);

    logic [WIDTH-1:0] data_q, data_d;
    logic             busy_q, busy_d;

    // Next-state: writeback loads data; reserve sets busy, otherwise writeback clears it.
    always_comb begin
        data_d = data_q;
        busy_d = busy_q;
        if (we) begin
            data_d = wdata;
            busy_d = 1'b0;
        end
        if (re) begin
            busy_d = 1'b1;
        end
    end

    // State register with asynchronous clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_q <= '0;
            busy_q <= 1'b0;
        end else begin
            data_q <= data_d;
            busy_q <= busy_d;
        end
    end

    assign data      = data_q;
    assign busy      = busy_q;
    assign busy_next = busy_d;

endmodule

// File: rtl/rf_sb.sv
// Register file with per-register pending-write scoreboard for the decode
// stage: two combinational read ports, one writeback port, one reserve port,
// a registered busy count and a sticky protocol-error flag.
// Optional build macro RF_BYPASS_EN: same-cycle write-through on both read
// ports (data and busy reflect the writeback/reserve happening this cycle).
module rf_sb
    import rf_pkg::*;
#(
    parameter int WIDTH = RF_DEFAULT_WIDTH,
    parameter int DEPTH = RF_DEFAULT_DEPTH,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [AW-1:0]    read1regsel,
    input  logic [AW-1:0]    read2regsel,
    output logic [WIDTH-1:0] read1data,
    output logic [WIDTH-1:0] read2data,
    output logic             read1busy,
    output logic             read2busy,
    input  logic             rsv,
    input  logic [AW-1:0]    rsvregsel,
    input  logic             write,
    input  logic [AW-1:0]    writeregsel,
    input  logic [WIDTH-1:0] writedata,
    output logic [AW:0]      busycount,
    output logic             err
);

    logic [DEPTH-1:0] we_vec;
    logic [DEPTH-1:0] re_vec;
    logic [DEPTH-1:0] busy_vec;
    logic [DEPTH-1:0] busy_next_vec;
    logic [WIDTH-1:0] data_arr [DEPTH];

    logic [AW:0] busycount_q, busycount_d;
    logic        err_q, err_d;
    rf_err_t     cause;

    // Entries with one-hot strobe decode. A select >= DEPTH matches no
    // entry, so an out-of-range strobe is dropped without any range compare.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
            assign we_vec[gi] = write & (writeregsel == AW'(gi));
            assign re_vec[gi] = rsv   & (rsvregsel   == AW'(gi));

            rf_entry #(
                .WIDTH (WIDTH)
            ) u_entry (
                .clk       (clk),
                .rst       (rst),
                .we        (we_vec[gi]),
                .re        (re_vec[gi]),
                .wdata     (writedata),
                .data      (data_arr[gi]),
                .busy      (busy_vec[gi]),
                .busy_next (busy_next_vec[gi])
            );
        end
    endgenerate

    // Read port 1 mux; out-of-range selects read as zero / not busy.
    always_comb begin
        read1data = '0;
        read1busy = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (read1regsel == AW'(i)) begin
`ifdef RF_BYPASS_EN
                read1data = we_vec[i] ? writedata : data_arr[i];
                read1busy = busy_next_vec[i];
`else
                read1data = data_arr[i];
                read1busy = busy_vec[i];
`endif
            end
        end
    end

    // Read port 2 mux; identical to port 1.
    always_comb begin
        read2data = '0;
        read2busy = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (read2regsel == AW'(i)) begin
`ifdef RF_BYPASS_EN
                read2data = we_vec[i] ? writedata : data_arr[i];
                read2busy = busy_next_vec[i];
`else
                read2data = data_arr[i];
                read2busy = busy_vec[i];
`endif
            end
        end
    end

    // Protocol checks and next busy count (count tracks the post-edge busy vector).
    always_comb begin
        logic [RF_MAX_DEPTH-1:0] busy_pad;
        busy_pad                 = '0;
        busy_pad[DEPTH-1:0]      = busy_next_vec;
        cause.wr_oob             = write & ~(|we_vec);
        cause.wr_unres           = |(we_vec & ~busy_vec);
        cause.rsv_oob            = rsv & ~(|re_vec);
        cause.rsv_dup            = |(re_vec & busy_vec & ~we_vec);
        err_d                    = err_q | (|cause);
        busycount_d              = (AW+1)'(popcount(busy_pad));
    end

    // Registered busy count and sticky error flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busycount_q <= '0;
            err_q       <= 1'b0;
        end else begin
            busycount_q <= busycount_d;
            err_q       <= err_d;
        end
    end

    assign busycount = busycount_q;
    assign err       = err_q;

endmodule

// File: tb/tb_rf_sb.sv
// Directed bench for rf_sb: an 8-entry instance for the main sequence and a
// 6-entry instance for out-of-range selects on a non-power-of-two depth.
module tb_rf_sb;

    logic        clk;
    logic        rst;

    // DEPTH = 8 instance
    logic [2:0]  r1sel, r2sel, rsel, wsel;
    logic [15:0] r1data, r2data, wdata;
    logic        r1busy, r2busy, rsv, write;
    logic [3:0]  bcount;
    logic        err;

    // DEPTH = 6 instance
    logic [2:0]  r1sel6, r2sel6, rsel6, wsel6;
    logic [15:0] r1data6, r2data6, wdata6;
    logic        r1busy6, r2busy6, rsv6, write6;
    logic [3:0]  bcount6;
    logic        err6;

    int n_cmp = 0;
    int n_mis = 0;

    rf_sb #(.WIDTH(16), .DEPTH(8)) u_dut (
        .clk(clk), .rst(rst),
        .read1regsel(r1sel), .read2regsel(r2sel),
        .read1data(r1data), .read2data(r2data),
        .read1busy(r1busy), .read2busy(r2busy),
        .rsv(rsv), .rsvregsel(rsel),
        .write(write), .writeregsel(wsel), .writedata(wdata),
        .busycount(bcount), .err(err)
    );

    rf_sb #(.WIDTH(16), .DEPTH(6)) u_dut6 (
        .clk(clk), .rst(rst),
        .read1regsel(r1sel6), .read2regsel(r2sel6),
        .read1data(r1data6), .read2data(r2data6),
        .read1busy(r1busy6), .read2busy(r2busy6),
        .rsv(rsv6), .rsvregsel(rsel6),
        .write(write6), .writeregsel(wsel6), .writedata(wdata6),
        .busycount(bcount6), .err(err6)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one edge, drop the strobes just after it, let reads settle.
    task automatic cycle();
        @(posedge clk);
        #1;
        rsv    = 1'b0;
        write  = 1'b0;
        rsv6   = 1'b0;
        write6 = 1'b0;
        #1;
    endtask

    initial begin
        rst = 1'b1;
        r1sel = 3'd0; r2sel = 3'd0; rsel = 3'd0; wsel = 3'd0; wdata = 16'h0;
        rsv = 1'b0; write = 1'b0;
        r1sel6 = 3'd0; r2sel6 = 3'd0; rsel6 = 3'd0; wsel6 = 3'd0; wdata6 = 16'h0;
        rsv6 = 1'b0; write6 = 1'b0;
        cycle();
        cycle();
        check("reset_bcount", {28'd0, bcount}, 32'd0);
        check("reset_err", {31'd0, err}, 32'd0);
        check("reset_r1data", {16'd0, r1data}, 32'd0);
        check("reset_r1busy", {31'd0, r1busy}, 32'd0);
        rst = 1'b0;

        // Reserve r2, then write it back.
        rsv = 1'b1; rsel = 3'd2; r1sel = 3'd2;
        cycle();
        check("rsv_r2_busy", {31'd0, r1busy}, 32'd1);
        check("rsv_r2_bcount", {28'd0, bcount}, 32'd1);
        write = 1'b1; wsel = 3'd2; wdata = 16'hBEEF;
        cycle();
        check("wb_r2_data", {16'd0, r1data}, 32'hBEEF);
        check("wb_r2_busy", {31'd0, r1busy}, 32'd0);
        check("wb_r2_bcount", {28'd0, bcount}, 32'd0);
        check("wb_r2_err", {31'd0, err}, 32'd0);

        // Reissue: r6 busy, then writeback + reserve r6 in the same cycle.
        rsv = 1'b1; rsel = 3'd6;
        cycle();
        write = 1'b1; wsel = 3'd6; wdata = 16'h0012; rsv = 1'b1; rsel = 3'd6; r1sel = 3'd6;
        cycle();
        check("reissue_data", {16'd0, r1data}, 32'h0012);
        check("reissue_busy", {31'd0, r1busy}, 32'd1);
        check("reissue_bcount", {28'd0, bcount}, 32'd1);
        check("reissue_err", {31'd0, err}, 32'd0);

        // Write-to-read visibility on port 2 for busy r7.
        rsv = 1'b1; rsel = 3'd7;
        cycle();
        check("rsv_r7_bcount", {28'd0, bcount}, 32'd2);
        write = 1'b1; wsel = 3'd7; wdata = 16'hA5A5; r2sel = 3'd7;
        #1;
`ifdef RF_BYPASS_EN
        check("byp_same_data", {16'd0, r2data}, 32'hA5A5);
        check("byp_same_busy", {31'd0, r2busy}, 32'd0);
`else
        check("nobyp_same_data", {16'd0, r2data}, 32'h0000);
        check("nobyp_same_busy", {31'd0, r2busy}, 32'd1);
`endif
        cycle();
        check("wb_r7_data", {16'd0, r2data}, 32'hA5A5);
        check("wb_r7_busy", {31'd0, r2busy}, 32'd0);
        check("wb_r7_bcount", {28'd0, bcount}, 32'd1);
        check("wb_r7_err", {31'd0, err}, 32'd0);

        // Unreserved writeback to r4 sets err; data still lands; err is sticky.
        write = 1'b1; wsel = 3'd4; wdata = 16'h1234; r1sel = 3'd4;
        cycle();
        check("unres_err", {31'd0, err}, 32'd1);
        check("unres_data", {16'd0, r1data}, 32'h1234);
        cycle();
        check("unres_err_sticky", {31'd0, err}, 32'd1);

        // Writes to r3 and r5, then a mid-cycle reset.
        write = 1'b1; wsel = 3'd3; wdata = 16'h0333;
        cycle();
        write = 1'b1; wsel = 3'd5; wdata = 16'h0555;
        cycle();
        r1sel = 3'd3; r2sel = 3'd5;
        #1;
        check("pre_rst_r3", {16'd0, r1data}, 32'h0333);
        check("pre_rst_r5", {16'd0, r2data}, 32'h0555);
        #2;
        rst = 1'b1;
        #1;
        check("rst_r3_data", {16'd0, r1data}, 32'd0);
        check("rst_r5_data", {16'd0, r2data}, 32'd0);
        check("rst_bcount", {28'd0, bcount}, 32'd0);
        check("rst_err", {31'd0, err}, 32'd0);
        r1sel = 3'd6;
        #1;
        check("rst_r6_busy", {31'd0, r1busy}, 32'd0);

        // Strobes during reset are discarded.
        rsv = 1'b1; rsel = 3'd0; write = 1'b1; wsel = 3'd0; wdata = 16'hFFFF; r1sel = 3'd0;
        cycle();
        check("rst_strobe_data", {16'd0, r1data}, 32'd0);
        check("rst_strobe_bcount", {28'd0, bcount}, 32'd0);
        rst = 1'b0;

        // Double reserve of r1.
        rsv = 1'b1; rsel = 3'd1;
        cycle();
        check("rsv1_first_err", {31'd0, err}, 32'd0);
        check("rsv1_first_bcount", {28'd0, bcount}, 32'd1);
        rsv = 1'b1; rsel = 3'd1;
        cycle();
        check("rsv1_dup_err", {31'd0, err}, 32'd1);
        check("rsv1_dup_bcount", {28'd0, bcount}, 32'd1);

        // DEPTH = 6: out-of-range writes and reserves are ignored but flagged.
        write6 = 1'b1; wsel6 = 3'd7; wdata6 = 16'hFFFF; r1sel6 = 3'd6; r2sel6 = 3'd5;
        cycle();
        check("d6_oob_err", {31'd0, err6}, 32'd1);
        check("d6_oob_bcount", {28'd0, bcount6}, 32'd0);
        check("d6_sel6_data", {16'd0, r1data6}, 32'd0);
        check("d6_sel6_busy", {31'd0, r1busy6}, 32'd0);
        check("d6_r5_data", {16'd0, r2data6}, 32'd0);
        rsv6 = 1'b1; rsel6 = 3'd6; write6 = 1'b1; wsel6 = 3'd6; wdata6 = 16'h7777;
        cycle();
        check("d6_rsv_oob_bcount", {28'd0, bcount6}, 32'd0);
        check("d6_wr6_data", {16'd0, r1data6}, 32'd0);
        check("d6_wr6_busy", {31'd0, r1busy6}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
